// File: rtl/imem_loader_if.sv
// imem_loader_if: handshake and write-port bundle between a byte-stream host, imem_loader and the instruction memory
//   master (host/bench) drives: start, load_len, byte_valid, byte_data
//   slave (imem_loader) drives: byte_ready, WE, A, WD, busy, done, error, cpu_rst
interface imem_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH:0]   load_len;
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  WE;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] WD;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic                  cpu_rst;
  modport master (
    output start, load_len, byte_valid, byte_data,
    input  byte_ready, WE, A, WD, busy, done, error, cpu_rst
  );
  modport slave (
    input  start, load_len, byte_valid, byte_data,
    output byte_ready, WE, A, WD, busy, done, error, cpu_rst
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory
//   clk, rst : clock, asynchronous active-high reset
//   ld       : imem_loader_if.slave (start/load_len, byte stream handshake, WE/A/WD write port,
//              busy, done pulse, error, cpu_rst hold-off)
//   Optional IMEM_LOADER_CHECKSUM_EN: XOR checksum over payload bytes, verified against one trailer byte.
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave ld
);
  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  typedef enum logic [2:0] {
    IDLE, RECV, WRITE, DONE
`ifdef IMEM_LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;
  // state entered once the payload is exhausted
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FIN = CHECK;
`else
  localparam state_t FIN = DONE;
`endif
  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d, idx_q, idx_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  loaded_q, loaded_d, err_q, err_d;
  logic                  acc;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            cs_q, cs_d;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      cs_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      cs_q     <= cs_d;
`endif
    end
  end
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    loaded_d = loaded_q;
    err_d    = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    cs_d     = cs_q;
`endif
    acc      = ld.byte_valid && ld.byte_ready;
    case (state_q)
      IDLE: if (ld.start) begin
        len_d    = ld.load_len > MAX_LEN ? MAX_LEN : ld.load_len;
        idx_d    = '0;
        cnt_d    = '0;
        loaded_d = 1'b0;
        err_d    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        cs_d     = '0;
`endif
        state_d  = ld.load_len == '0 ? FIN : RECV;
      end
      RECV: if (acc) begin
        word_d[{cnt_q, 3'b000} +: 8] = ld.byte_data;
        cnt_d = cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        cs_d  = cs_q ^ ld.byte_data;
`endif
        state_d = cnt_q == 2'd3 ? WRITE : RECV;
      end
      WRITE: begin
        idx_d   = idx_q + 1'b1;
        state_d = idx_q + 1'b1 == len_q ? FIN : RECV;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: if (acc) begin
        err_d   = ld.byte_data != cs_q;
        state_d = DONE;
      end
`endif
      DONE: begin
        loaded_d = !err_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign ld.byte_ready = state_q == RECV || state_q == CHECK;
`else
  assign ld.byte_ready = state_q == RECV;
`endif
  assign ld.WE      = state_q == WRITE;
  assign ld.A       = ld.WE ? DATA_WIDTH'({idx_q, 2'b00}) : '0;
  assign ld.WD      = ld.WE ? word_q : '0;
  assign ld.busy    = state_q != IDLE;
  assign ld.done    = state_q == DONE;
  assign ld.error   = err_q;
  assign ld.cpu_rst = !loaded_q || ld.busy;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and randomized checks of imem_loader against a word-assembly model
module tb_imem_loader;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam bit CK =
`ifdef IMEM_LOADER_CHECKSUM_EN
    1'b1;
`else
    1'b0;
`endif
  typedef struct {
    logic [8:0]  len;
    int          mode;
    bit          poke;
    logic [31:0] w0;
    logic [31:0] w1;
    int          lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  imem_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ld();
  imem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .ld(ld));
  int total = 0, bad = 0, cyc = 0, leak = 0, dones = 0;
  bit bad_trl = 1'b0;
  logic [31:0] wq_a[$], wq_d[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ld.WE) begin
      wq_a.push_back(ld.A);
      wq_d.push_back(ld.WD);
    end else if (ld.A != '0 || ld.WD != '0) leak <= leak + 1;
    if (ld.done) dones <= dones + 1;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic run_load(input logic [8:0] len, input logic [7:0] b[$], input int mode, input bit poke, output int lat);
    int i, n, c0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] cs;
    cs = '0;
    foreach (b[k]) cs ^= b[k];
    b.push_back(cs ^ {7'b0, bad_trl});
`endif
    @(negedge clk);
    ld.start = 1'b1;
    ld.load_len = len;
    c0 = cyc;
    @(negedge clk);
    ld.start = 1'b0;
    i = 0;
    n = 0;
    while (i < b.size() && n < 20000) begin
      ld.start = poke && n == 2;
      ld.load_len = ld.start ? 9'd0 : len;
      ld.byte_valid = mode == 0 ? 1'b1 : mode == 1 ? ~n[0] : 1'($urandom_range(0, 1));
      ld.byte_data = b[i];
      if (ld.byte_valid && ld.byte_ready) i++;
      @(negedge clk);
      n++;
    end
    ld.start = 1'b0;
    ld.byte_valid = 1'b0;
    n = 0;
    while (!ld.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", ld.done, 1);
    lat = cyc - c0;
    @(negedge clk);
    #1;
  endtask
  // expected writes: word w is bytes 4w..4w+3 little-endian at byte address 4w, len capped at 256
  task automatic verify(input string nm, input logic [8:0] len, input logic [7:0] b[$], input int d0);
    int nw;
    logic [31:0] e;
    bit fail_ck;
    nw = len > 9'd256 ? 256 : int'(len);
    fail_ck = CK && bad_trl;
    chk({nm, "_nwr"}, wq_a.size(), nw);
    for (int w = 0; w < nw && w < wq_a.size(); w++) begin
      e = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
      chk({nm, "_addr"}, wq_a[w], 4 * w);
      chk({nm, "_data"}, wq_d[w], e);
    end
    chk({nm, "_dones"}, dones - d0, 1);
    chk({nm, "_busy"}, ld.busy, 0);
    chk({nm, "_error"}, ld.error, fail_ck);
    chk({nm, "_cpu_rst"}, ld.cpu_rst, fail_ck);
    wq_a.delete();
    wq_d.delete();
  endtask
  initial begin
    vec_t vt[5];
    logic [7:0] b[$];
    logic [31:0] e;
    logic [8:0] len;
    int lat, d0;
    vt[0] = '{9'd2, 0, 1'b0, 32'h00100513, 32'h00400593, 11};
    vt[1] = '{9'd2, 1, 1'b0, 32'h00100513, 32'h00400593, 0};
    vt[2] = '{9'd0, 0, 1'b0, 32'h0, 32'h0, 1};
    vt[3] = '{9'd1, 0, 1'b0, 32'hEFBEADDE, 32'h0, 6};
    vt[4] = '{9'd2, 0, 1'b1, 32'hCAFEF00D, 32'h12345678, 0};
    ld.start = 1'b0;
    ld.load_len = '0;
    ld.byte_valid = 1'b0;
    ld.byte_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_cpu_rst", ld.cpu_rst, 1);
    chk("idle_busy", ld.busy, 0);
    chk("idle_ready", ld.byte_ready, 0);
    chk("idle_we", ld.WE, 0);
    chk("idle_done", ld.done, 0);
    chk("idle_error", ld.error, 0);
    chk("idle_a_wd", {ld.A, ld.WD}, 0);
    for (int k = 0; k < 5; k++) begin
      b = {};
      for (int w = 0; w < int'(vt[k].len); w++) begin
        e = w == 0 ? vt[k].w0 : vt[k].w1;
        for (int j = 0; j < 4; j++) b.push_back(e[8*j +: 8]);
      end
      d0 = dones;
      run_load(vt[k].len, b, vt[k].mode, vt[k].poke, lat);
      verify("vec", vt[k].len, b, d0);
      if (vt[k].lat != 0) chk("latency", lat, vt[k].lat + int'(CK));
    end
    @(negedge clk);
    ld.start = 1'b1;
    ld.load_len = 9'd1;
    @(negedge clk);
    ld.start = 1'b0;
    ld.byte_valid = 1'b1;
    ld.byte_data = 8'h13;
    @(negedge clk);
    ld.byte_data = 8'h05;
    @(negedge clk);
    ld.byte_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_busy", ld.busy, 0);
    chk("rst_ready", ld.byte_ready, 0);
    chk("rst_cpu_rst", ld.cpu_rst, 1);
    chk("rst_we", ld.WE, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("rst_no_write", wq_a.size(), 0);
    chk("rst_cpu_rst_held", ld.cpu_rst, 1);
    b = {8'h13, 8'h05, 8'h10, 8'h00};
    d0 = dones;
    run_load(9'd1, b, 0, 1'b0, lat);
    verify("after_rst", 9'd1, b, d0);
    for (int r = 0; r < 8; r++) begin
      len = 9'($urandom_range(1, 6));
      b = {};
      for (int j = 0; j < 4 * int'(len); j++) b.push_back(8'($urandom));
      d0 = dones;
      run_load(len, b, 2, 1'b0, lat);
      verify("rand", len, b, d0);
    end
    b = {};
    for (int j = 0; j < 1024; j++) b.push_back(8'($urandom));
    d0 = dones;
    run_load(9'h1FF, b, 0, 1'b0, lat);
    verify("sat", 9'h1FF, b, d0);
    bad_trl = 1'b1;
    b = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    d0 = dones;
    run_load(9'd1, b, 0, 1'b0, lat);
    verify("bad_trailer", 9'd1, b, d0);
    bad_trl = 1'b0;
    d0 = dones;
    run_load(9'd1, b, 0, 1'b0, lat);
    verify("good_trailer", 9'd1, b, d0);
    chk("idle_bus_zero", leak, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
